axis_pretrigger_capture: RTL and testbench

- Capture sequencer directly downstream of the threshold trigger detector.
- Consumes the free-running ADC sample stream plus the single-cycle trigger flag.
- Gates a pre-trigger/post-trigger window of samples to a downstream ring-buffer writer.
- Reports the ring index of the trigger sample and a completion flag to the PS register bank.

---
 rtl/axis_pretrigger_capture.sv | 140 ++++++++++++++
 tb/tb_axis_pretrigger_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/axis_pretrigger_capture.sv
// Pre/post-trigger capture sequencer gating an ADC sample stream to a ring-buffer writer.
// Latency: data, valid and tuser are zero-cycle combinational; state/trg_addr/complete are registered.
// Backpressure: none; tready is tied high and the downstream writer must accept every valid.
// Optional auto-trigger after N armed samples: define AXIS_PRETRIGGER_CAPTURE_AUTO_EN.
module axis_pretrigger_capture #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 16
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        run_flag,
   input  logic                        trg_flag,
   input  logic [CNTR_WIDTH-1:0]       pre_data,
   input  logic [CNTR_WIDTH-1:0]       tot_data,
`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
   input  logic [CNTR_WIDTH-1:0]       auto_data,
`endif
   output logic [CNTR_WIDTH-1:0]       trg_addr,
   output logic                        complete,
   output logic [1:0]                  sts_data,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tuser
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRE   = 2'd1,
      ARMED = 2'd2,
      POST  = 2'd3
   } state_t;

   localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state;
   logic                  run_q;
   logic [CNTR_WIDTH-1:0] pre_len;
   logic [CNTR_WIDTH-1:0] tot_len;
   logic [CNTR_WIDTH-1:0] idx;
   logic [CNTR_WIDTH-1:0] cnt;
   logic [CNTR_WIDTH-1:0] idx_nxt;
   logic [CNTR_WIDTH-1:0] post_len;
   logic                  start;
   logic                  trig_hit;

   assign start    = run_flag & ~run_q;
   assign idx_nxt  = (idx == tot_len - ONE) ? '0 : idx + ONE;
   assign post_len = tot_len - pre_len - ONE;

`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
   // auto_cnt holds the number of armed samples already seen, so the hit lands on sample auto_data
   logic [CNTR_WIDTH-1:0] auto_cnt;
   logic                  auto_hit;
   assign auto_hit = (auto_data != '0) && ((auto_cnt + ONE) == auto_data);
   assign trig_hit = s_axis_tvalid & (trg_flag | auto_hit);
`else
   assign trig_hit = s_axis_tvalid & trg_flag;
`endif

   assign s_axis_tready = 1'b1;
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tvalid = s_axis_tvalid & (state != IDLE);
   assign m_axis_tuser  = trig_hit & (state == ARMED);
   assign sts_data      = state;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state    <= IDLE;
         run_q    <= 1'b0;
         pre_len  <= '0;
         tot_len  <= '0;
         idx      <= '0;
         cnt      <= '0;
         trg_addr <= '0;
         complete <= 1'b0;
`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
         auto_cnt <= '0;
`endif
      end else begin
         run_q <= run_flag;
         case (state)
            IDLE: begin
               if (start) begin
                  pre_len  <= pre_data;
                  tot_len  <= tot_data;
                  idx      <= '0;
                  cnt      <= '0;
                  complete <= 1'b0;
`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
                  auto_cnt <= '0;
`endif
                  state    <= (pre_data == '0) ? ARMED : PRE;
               end
            end
            default: begin
               if (!run_flag) begin
                  state    <= IDLE;
                  complete <= 1'b0;
               end else if (s_axis_tvalid) begin
                  idx <= idx_nxt;
                  case (state)
                     PRE: begin
                        cnt <= cnt + ONE;
                        if ((cnt + ONE) == pre_len) state <= ARMED;
                     end
                     ARMED: begin
`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
                        auto_cnt <= auto_cnt + ONE;
`endif
                        if (trig_hit) begin
                           trg_addr <= idx;
                           cnt      <= post_len;
                           if (post_len == '0) begin
                              state    <= IDLE;
                              complete <= 1'b1;
                           end else begin
                              state <= POST;
                           end
                        end
                     end
                     POST: begin
                        cnt <= cnt - ONE;
                        // <= also ends a window whose counter was loaded with 0 from bad lengths
                        if (cnt <= ONE) begin
                           state    <= IDLE;
                           complete <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pretrigger_capture.sv
// Directed bench for axis_pretrigger_capture: table of capture windows plus reset, abort and auto-trigger sequences.
module tb_axis_pretrigger_capture;

   logic        aclk = 1'b0;
   logic        areset;
   logic        run_flag;
   logic        trg_flag;
   logic [15:0] pre_data;
   logic [15:0] tot_data;
`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
   logic [15:0] auto_data;
`endif
   logic [15:0] trg_addr;
   logic        complete;
   logic [1:0]  sts_data;
   logic        s_axis_tready;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tuser;

   int errors = 0;
   int checks = 0;

   always #5 aclk = ~aclk;

   axis_pretrigger_capture #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(16)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .run_flag      (run_flag),
      .trg_flag      (trg_flag),
      .pre_data      (pre_data),
      .tot_data      (tot_data),
`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
      .auto_data     (auto_data),
`endif
      .trg_addr      (trg_addr),
      .complete      (complete),
      .sts_data      (sts_data),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tuser  (m_axis_tuser)
   );

   typedef struct {
      int pre;
      int tot;
      int trg;       // sample number carrying trg_flag, -1 for none
      int early;     // extra trg_flag pulse expected to be ignored, -1 for none
      int tog;       // 1: tvalid alternates and trg_flag is held high on idle cycles
      int exp_addr;
      int exp_fwd;
      int exp_last;
      int exp_tu;    // sample number expected to carry tuser
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic capture(input vec_t v, input string nm);
      int  n = 0, fwd = 0, last = -1, tu = 0, tu_at = -1, cyc = 0;
      bit  done = 1'b0;
      bit  vld;
      run_flag = 1'b0; s_axis_tvalid = 1'b0; trg_flag = 1'b0;
      tick();
      pre_data = 16'(v.pre); tot_data = 16'(v.tot); run_flag = 1'b1;
      tick();
      check({nm, " complete cleared at start"}, int'(complete), 0);
      check({nm, " state after start"}, int'(sts_data), (v.pre == 0) ? 2 : 1);
      while (!done && cyc < 500) begin
         vld = (v.tog != 0) ? (cyc % 2 == 0) : 1'b1;
         s_axis_tvalid = vld;
         s_axis_tdata  = 32'(n);
         trg_flag      = vld ? (n == v.trg || n == v.early) : (v.tog != 0);
         @(negedge aclk);
         if (m_axis_tvalid) begin
            fwd++;
            last = int'(m_axis_tdata);
         end
         if (m_axis_tuser) begin
            tu++;
            tu_at = int'(m_axis_tdata);
         end
         tick();
         if (vld) n++;
         cyc++;
         done = complete;
      end
      check({nm, " completed within budget"}, int'(done), 1);
      check({nm, " trg_addr"}, int'(trg_addr), v.exp_addr);
      check({nm, " forwarded count"}, fwd, v.exp_fwd);
      check({nm, " last forwarded sample"}, last, v.exp_last);
      check({nm, " tuser count"}, tu, 1);
      check({nm, " tuser sample"}, tu_at, v.exp_tu);
      s_axis_tvalid = 1'b1; trg_flag = 1'b0;
      @(negedge aclk);
      check({nm, " valid gated when done"}, int'(m_axis_tvalid), 0);
      check({nm, " state idle when done"}, int'(sts_data), 0);
      tick();
      check({nm, " complete held"}, int'(complete), 1);
   endtask

   initial begin
      //           pre tot trg early tog addr fwd last tu
      vecs[0] = '{4, 16, 10,  2, 0, 10, 22, 21, 10};
      vecs[1] = '{4, 16, 10,  2, 1, 10, 22, 21, 10};
      vecs[2] = '{0,  8,  0, -1, 0,  0,  8,  7,  0};
      vecs[3] = '{4,  8, 24, -1, 0,  0, 28, 27, 24};
      vecs[4] = '{4,  5,  4, -1, 0,  4,  5,  4,  4};
      vecs[5] = '{0,  1,  0, -1, 0,  0,  1,  0,  0};
      vecs[6] = '{3,  6,  7, -1, 1,  1,  10, 9,  7};

      areset = 1'b1; run_flag = 1'b1; trg_flag = 1'b0;
      pre_data = 16'd4; tot_data = 16'd16;
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0;
`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
      auto_data = 16'd0;
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         check("reset m_axis_tvalid", int'(m_axis_tvalid), 0);
         check("reset complete", int'(complete), 0);
         check("reset sts_data", int'(sts_data), 0);
      end
      check("reset trg_addr", int'(trg_addr), 0);
      check("tready tied high", int'(s_axis_tready), 1);
      run_flag = 1'b0;
      tick();
      areset = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) capture(vecs[i], $sformatf("vec%0d", i));

      // abort in POST: trigger at sample 5 with pre=4, tot=16, drop run_flag after sample 7
      run_flag = 1'b0; s_axis_tvalid = 1'b0; trg_flag = 1'b0;
      tick();
      pre_data = 16'd4; tot_data = 16'd16; run_flag = 1'b1;
      tick();
      for (int n = 0; n < 8; n++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(n); trg_flag = (n == 5);
         tick();
      end
      trg_flag = 1'b0;
      check("abort state before drop", int'(sts_data), 3);
      run_flag = 1'b0; s_axis_tdata = 32'd8;
      @(negedge aclk);
      check("abort sample still forwarded", int'(m_axis_tvalid), 1);
      tick();
      check("abort state idle", int'(sts_data), 0);
      check("abort complete low", int'(complete), 0);
      check("abort trg_addr held", int'(trg_addr), 5);
      @(negedge aclk);
      check("abort valid gated", int'(m_axis_tvalid), 0);
      capture('{2, 4, 3, -1, 0, 3, 5, 4, 3}, "restart");

`ifdef AXIS_PRETRIGGER_CAPTURE_AUTO_EN
      auto_data = 16'd5;
      capture('{2, 8, -1, -1, 0, 6, 12, 11, 6}, "auto");
      auto_data = 16'd0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
